// File: rtl/lock_pkg.sv
// Shared types and helpers for the lock button conditioner.
package lock_pkg;

    localparam int NUM_BTNS = 2;
    localparam int BTN_ZERO = 0;
    localparam int BTN_ONE  = 1;

    typedef logic [NUM_BTNS-1:0] btn_vec_t;

    // A press only counts when it is the sole rising button and the other is not held.
    function automatic btn_vec_t arbitrate(input btn_vec_t rise, input btn_vec_t level);
        btn_vec_t pulse;
        pulse           = '0;
        pulse[BTN_ZERO] = rise[BTN_ZERO] & ~rise[BTN_ONE]  & ~level[BTN_ONE];
        pulse[BTN_ONE]  = rise[BTN_ONE]  & ~rise[BTN_ZERO] & ~level[BTN_ZERO];
        return pulse;
    endfunction

endpackage

// File: rtl/lock_debounce_bit.sv
// One button channel: synchroniser, debounce counter, debounced level,
// arming flag and registered rising-edge detect.
module lock_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic armed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] valid_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   level_reg;
    logic                   level_next;
    logic                   level_prev_reg;
    logic                   armed_reg;
    logic                   armed_next;
    logic                   s;

    assign s = sync_reg[SYNC_STAGES-1];

    always_comb begin
        cnt_next   = cnt_reg;
        level_next = level_reg;
        armed_next = armed_reg;
        if (s == level_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
            level_next = s;
            cnt_next   = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
        // Only trust s once it carries a real post-reset sample, otherwise the
        // zeroed chain would arm a button that was held through reset.
        if (valid_reg[SYNC_STAGES-1] && !s && !level_reg) begin
            armed_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg       <= '0;
            valid_reg      <= '0;
            cnt_reg        <= '0;
            level_reg      <= 1'b0;
            level_prev_reg <= 1'b0;
            armed_reg      <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[SYNC_STAGES-2:0], raw};
            valid_reg      <= {valid_reg[SYNC_STAGES-2:0], 1'b1};
            cnt_reg        <= cnt_next;
            level_reg      <= level_next;
            level_prev_reg <= level_reg;
            armed_reg      <= armed_next;
        end
    end

    assign level = level_reg;
    assign rise  = level_reg & ~level_prev_reg & armed_reg;
    assign armed = armed_reg;

endmodule

// File: rtl/lock_button_conditioner.sv
// Two-button front-end: per-button debounce channels plus press arbitration.
// Optional chord_clr output is built when LOCK_BTN_CHORD_CLR_EN is defined.
module lock_button_conditioner
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  btn_vec_t btn_raw,
    output btn_vec_t b,
    output btn_vec_t btn_level
`ifdef LOCK_BTN_CHORD_CLR_EN
    ,
    output logic     chord_clr
`endif
);

    btn_vec_t level_w;
    btn_vec_t rise_w;
    btn_vec_t armed_w;
    btn_vec_t b_reg;

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            lock_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_STAGES    (SYNC_STAGES)
            ) u_bit (
                .clk  (clk),
                .rst  (rst),
                .raw  (btn_raw[gi]),
                .level(level_w[gi]),
                .rise (rise_w[gi]),
                .armed(armed_w[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            b_reg <= '0;
        end else begin
            b_reg <= arbitrate(rise_w, level_w);
        end
    end

    assign b         = b_reg;
    assign btn_level = level_w;

`ifdef LOCK_BTN_CHORD_CLR_EN
    logic chord_clr_reg;

    // Fires on the edge the pair becomes 11; a b pulse is impossible then
    // because each button sees the other debounced high.
    always_ff @(posedge clk) begin
        if (rst) begin
            chord_clr_reg <= 1'b0;
        end else begin
            chord_clr_reg <= (&level_w) & (|rise_w) & (&armed_w);
        end
    end

    assign chord_clr = chord_clr_reg;
`else
    logic unused_armed;
    assign unused_armed = &{1'b0, armed_w};
`endif

endmodule

// File: tb/tb_lock_button_conditioner.sv
// Directed bench for lock_button_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_lock_button_conditioner;
    import lock_pkg::*;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    btn_vec_t btn_raw = '0;
    btn_vec_t b;
    btn_vec_t btn_level;
`ifdef LOCK_BTN_CHORD_CLR_EN
    logic     chord_clr;
`endif

    int checks = 0;
    int errors = 0;
    int p0 = 0;
    int p1 = 0;
    int p_both = 0;
    int p_chord = 0;
    int lvl_hits = 0;

    lock_button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .b        (b),
        .btn_level(btn_level)
`ifdef LOCK_BTN_CHORD_CLR_EN
        ,
        .chord_clr(chord_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_counts();
        p0 = 0;
        p1 = 0;
        p_chord = 0;
        lvl_hits = 0;
    endtask

    // Advance n edges, sampling 1 time unit after each rising edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (b == 2'b01) p0++;
            if (b == 2'b10) p1++;
            if (b == 2'b11) p_both++;
            if (btn_level != 2'b00) lvl_hits++;
`ifdef LOCK_BTN_CHORD_CLR_EN
            if (chord_clr) p_chord++;
`endif
        end
    endtask

    initial begin
        // Reset state
        run(3);
        check("rst_b", 8'(b), 8'h0);
        check("rst_lvl", 8'(btn_level), 8'h0);
        rst = 1'b0;
        run(6);

        // Clean press: first sampled at edge 0
        btn_raw = 2'b01;
        run(5);
        check("cp_lvl_e4", 8'(btn_level), 8'h0);
        run(1);
        check("cp_lvl_e5", 8'(btn_level), 8'h1);
        check("cp_b_e5", 8'(b), 8'h0);
        run(1);
        check("cp_b_e6", 8'(b), 8'h1);
        run(1);
        check("cp_b_e7", 8'(b), 8'h0);
        clear_counts();
        run(10);
        check("cp_hold_p0", 8'(p0), 8'h0);
        check("cp_hold_lvl", 8'(btn_level), 8'h1);
        btn_raw = 2'b00;
        clear_counts();
        run(10);
        check("cp_rel_pulses", 8'(p0 + p1), 8'h0);
        check("cp_rel_lvl", 8'(btn_level), 8'h0);

        // Bounce on button 1
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            btn_raw = 2'b10; run(3);
            btn_raw = 2'b00; run(1);
            btn_raw = 2'b10; run(2);
            btn_raw = 2'b00; run(1);
        end
        check("bn_pulses", 8'(p0 + p1), 8'h0);
        check("bn_lvl_hits", 8'(lvl_hits), 8'h0);
        clear_counts();
        btn_raw = 2'b10;
        run(10);
        check("bn_hold_p1", 8'(p1), 8'h1);
        check("bn_hold_p0", 8'(p0), 8'h0);
        btn_raw = 2'b00;
        run(10);
        check("bn_rel_lvl", 8'(btn_level), 8'h0);

        // Simultaneous press
        clear_counts();
        btn_raw = 2'b11;
        run(6);
`ifdef LOCK_BTN_CHORD_CLR_EN
        check("sp_chord_e5", 8'(chord_clr), 8'h0);
        run(1);
        check("sp_chord_e6", 8'(chord_clr), 8'h1);
        check("sp_b_e6", 8'(b), 8'h0);
        run(1);
        check("sp_chord_e7", 8'(chord_clr), 8'h0);
        run(4);
`else
        run(6);
`endif
        check("sp_pulses", 8'(p0 + p1), 8'h0);
        check("sp_lvl", 8'(btn_level), 8'h3);
        clear_counts();
        btn_raw = 2'b00;
        run(10);
        check("sp_rel_pulses", 8'(p0 + p1 + p_chord), 8'h0);
        check("sp_rel_lvl", 8'(btn_level), 8'h0);

        // Chord: button 1 held, then button 0 pressed
        clear_counts();
        btn_raw = 2'b10;
        run(10);
        check("ch_p1", 8'(p1), 8'h1);
        check("ch_lvl1", 8'(btn_level), 8'h2);
        clear_counts();
        btn_raw = 2'b11;
        run(10);
        check("ch_pulses", 8'(p0 + p1), 8'h0);
        check("ch_lvl11", 8'(btn_level), 8'h3);
`ifdef LOCK_BTN_CHORD_CLR_EN
        check("ch_chord", 8'(p_chord), 8'h1);
`endif
        clear_counts();
        btn_raw = 2'b00;
        run(10);
        check("ch_rel_pulses", 8'(p0 + p1), 8'h0);
        check("ch_rel_lvl", 8'(btn_level), 8'h0);

        // Reset while held
        btn_raw = 2'b01;
        run(2);
        rst = 1'b1;
        run(3);
        check("rh_rst_b", 8'(b), 8'h0);
        check("rh_rst_lvl", 8'(btn_level), 8'h0);
        rst = 1'b0;
        clear_counts();
        run(15);
        check("rh_hold_p0", 8'(p0), 8'h0);
        check("rh_hold_lvl", 8'(btn_level), 8'h1);
        btn_raw = 2'b00;
        run(10);
        check("rh_rel_p0", 8'(p0), 8'h0);
        check("rh_rel_lvl", 8'(btn_level), 8'h0);
        clear_counts();
        btn_raw = 2'b01;
        run(6);
        check("rh_pre_p0", 8'(p0), 8'h0);
        run(1);
        check("rh_b_e6", 8'(b), 8'h1);
        run(1);
        check("rh_b_e7", 8'(b), 8'h0);
        clear_counts();
        run(5);
        check("rh_tail_p0", 8'(p0), 8'h0);

        check("never_both", 8'(p_both), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
